// File: rtl/axis_srl_fifo_status.sv
// -----------------------------------------------------------------------------
// axis_srl_fifo_status
//
// Shallow AXI4-Stream FIFO for elasticity between stream stages. Storage is a
// shift register (maps onto LUT shift registers, no block RAM). New words
// always enter at sr[0], and the oldest word sits at sr[count-1]. The block
// also reports occupancy and threshold status, and it provides a synchronous
// flush.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_axis_*            upstream slave stream (tdata/tkeep/tvalid/tready/
//                       tlast/tid/tdest/tuser)
//   m_axis_*            downstream master stream (same field set)
//   flush               synchronous clear of stored contents
//   status_count        occupancy, 0..DEPTH
//   status_full         occupancy == DEPTH
//   status_empty        occupancy == 0
//   status_almost_full  occupancy >= ALMOST_FULL_LEVEL
//
// Sideband fields that are enabled are packed above tdata in this order:
// keep, last, id, dest, user. Disabled input fields are ignored. Disabled
// output fields drive constants: tkeep all-ones, tlast 1, tid/tdest/tuser 0.
// -----------------------------------------------------------------------------
module axis_srl_fifo_status #(
  parameter int DATA_WIDTH        = 8,
  parameter bit KEEP_ENABLE       = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH        = (DATA_WIDTH / 8),
  parameter bit LAST_ENABLE       = 1'b1,
  parameter bit ID_ENABLE         = 1'b0,
  parameter int ID_WIDTH          = 8,
  parameter bit DEST_ENABLE       = 1'b0,
  parameter int DEST_WIDTH        = 8,
  parameter bit USER_ENABLE       = 1'b1,
  parameter int USER_WIDTH        = 1,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
  localparam int CW               = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic                  flush,
  output logic [CW-1:0]         status_count,
  output logic                  status_full,
  output logic                  status_empty,
  output logic                  status_almost_full
);

  // Bit offsets of each sideband field inside the stored word.
  localparam int KEEP_OFF = DATA_WIDTH;
  localparam int LAST_OFF = KEEP_OFF + (KEEP_ENABLE ? KEEP_WIDTH : 0);
  localparam int ID_OFF   = LAST_OFF + (LAST_ENABLE ? 1 : 0);
  localparam int DEST_OFF = ID_OFF   + (ID_ENABLE   ? ID_WIDTH   : 0);
  localparam int USER_OFF = DEST_OFF + (DEST_ENABLE ? DEST_WIDTH : 0);
  localparam int WIDTH    = USER_OFF + (USER_ENABLE ? USER_WIDTH : 0);
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] s_word;
  logic [WIDTH-1:0] m_word;
  logic [WIDTH-1:0] sr [DEPTH];
  logic [CW-1:0]    count;
  logic             full_reg;
  logic             push;
  logic             pop;
  logic [AW-1:0]    head;

  // ---------------------------------------------------------------------------
  // Packing and unpacking of the stored word
  // ---------------------------------------------------------------------------
  assign s_word[DATA_WIDTH-1:0] = s_axis_tdata;
  assign m_axis_tdata           = m_word[DATA_WIDTH-1:0];

  generate
    if (KEEP_ENABLE) begin : g_keep
      assign s_word[LAST_OFF-1:KEEP_OFF] = s_axis_tkeep;
      assign m_axis_tkeep                = m_word[LAST_OFF-1:KEEP_OFF];
    end else begin : g_no_keep
      assign m_axis_tkeep = '1;
    end

    if (LAST_ENABLE) begin : g_last
      assign s_word[LAST_OFF] = s_axis_tlast;
      assign m_axis_tlast     = m_word[LAST_OFF];
    end else begin : g_no_last
      assign m_axis_tlast = 1'b1;
    end

    if (ID_ENABLE) begin : g_id
      assign s_word[DEST_OFF-1:ID_OFF] = s_axis_tid;
      assign m_axis_tid                = m_word[DEST_OFF-1:ID_OFF];
    end else begin : g_no_id
      assign m_axis_tid = '0;
    end

    if (DEST_ENABLE) begin : g_dest
      assign s_word[USER_OFF-1:DEST_OFF] = s_axis_tdest;
      assign m_axis_tdest                = m_word[USER_OFF-1:DEST_OFF];
    end else begin : g_no_dest
      assign m_axis_tdest = '0;
    end

    if (USER_ENABLE) begin : g_user
      assign s_word[WIDTH-1:USER_OFF] = s_axis_tuser;
      assign m_axis_tuser             = m_word[WIDTH-1:USER_OFF];
    end else begin : g_no_user
      assign m_axis_tuser = '0;
    end
  endgenerate

  // Inputs of disabled fields have no load. This sink names them.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep, s_axis_tlast, s_axis_tid,
                           s_axis_tdest, s_axis_tuser};

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Both ready and valid come only from registers. This breaks any
  // combinational path through the FIFO. The cost is that a full FIFO cannot
  // accept a word in the same cycle that it pops one.
  assign s_axis_tready = !full_reg;
  assign m_axis_tvalid = (count != '0);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;

  // ---------------------------------------------------------------------------
  // Shift-register storage
  // ---------------------------------------------------------------------------
  // NOTE: storage has no reset, so it can map onto LUT shift registers. Only
  // count decides which entries are live, so stale contents are unreachable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every sr[i]
    // samples its neighbour's pre-edge value and the chain shifts exactly one
    // place.
    if (push && !flush) begin
      sr[0] <= s_word;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  // Read pointer to the oldest entry (count-1). When the FIFO is empty the
  // pointer is parked at 0, where the output is don't-care.
  always_comb begin
    // NOTE: a default is assigned first so every path drives head and no latch
    // is inferred.
    head = '0;
    if (count != '0) begin
      head = AW'(count - CW'(1));
    end
  end

  assign m_word = sr[head];

  // ---------------------------------------------------------------------------
  // Occupancy. full_reg is updated alongside count so it stays exact.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count    <= '0;
      full_reg <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          count    <= count + CW'(1);
          full_reg <= (count == CW'(DEPTH - 1));
        end
        2'b01: begin
          count    <= count - CW'(1);
          full_reg <= 1'b0;
        end
        default: ;  // idle, or push and pop together: occupancy unchanged
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign status_count       = count;
  assign status_full        = (count == CW'(DEPTH));
  assign status_empty       = (count == '0);
  assign status_almost_full = (count >= CW'(ALMOST_FULL_LEVEL));

endmodule

// File: tb/tb_axis_srl_fifo_status.sv
// -----------------------------------------------------------------------------
// tb_axis_srl_fifo_status
//
// Directed bench for axis_srl_fifo_status. Instance "a" uses the defaults
// (DEPTH=4, 8-bit data, tlast and tuser carried). Instance "b" is a DEPTH=2
// FIFO with keep and last disabled. It runs a random valid/ready pattern and
// is compared against a queue model.
// -----------------------------------------------------------------------------
module tb_axis_srl_fifo_status;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------- DUT a ---
  logic [7:0] a_s_tdata;
  logic       a_s_tvalid, a_s_tready, a_s_tlast;
  logic [0:0] a_s_tuser;
  logic [7:0] a_m_tdata;
  logic [0:0] a_m_tkeep;
  logic       a_m_tvalid, a_m_tready, a_m_tlast;
  logic [7:0] a_m_tid, a_m_tdest;
  logic [0:0] a_m_tuser;
  logic       a_flush;
  logic [2:0] a_count;
  logic       a_full, a_empty, a_afull;

  axis_srl_fifo_status #(.DEPTH(4)) dut_a (
    .clk                (clk),
    .rst                (rst),
    .s_axis_tdata       (a_s_tdata),
    .s_axis_tkeep       (1'b1),
    .s_axis_tvalid      (a_s_tvalid),
    .s_axis_tready      (a_s_tready),
    .s_axis_tlast       (a_s_tlast),
    .s_axis_tid         (8'h00),
    .s_axis_tdest       (8'h00),
    .s_axis_tuser       (a_s_tuser),
    .m_axis_tdata       (a_m_tdata),
    .m_axis_tkeep       (a_m_tkeep),
    .m_axis_tvalid      (a_m_tvalid),
    .m_axis_tready      (a_m_tready),
    .m_axis_tlast       (a_m_tlast),
    .m_axis_tid         (a_m_tid),
    .m_axis_tdest       (a_m_tdest),
    .m_axis_tuser       (a_m_tuser),
    .flush              (a_flush),
    .status_count       (a_count),
    .status_full        (a_full),
    .status_empty       (a_empty),
    .status_almost_full (a_afull)
  );

  // ---------------------------------------------------------------- DUT b ---
  logic [7:0] b_s_tdata;
  logic       b_s_tvalid, b_s_tready;
  logic [7:0] b_m_tdata;
  logic [0:0] b_m_tkeep;
  logic       b_m_tvalid, b_m_tready, b_m_tlast;
  logic [7:0] b_m_tid, b_m_tdest;
  logic [0:0] b_m_tuser;
  logic [1:0] b_count;
  logic       b_full, b_empty, b_afull;

  axis_srl_fifo_status #(
    .DEPTH       (2),
    .KEEP_ENABLE (1'b0),
    .LAST_ENABLE (1'b0)
  ) dut_b (
    .clk                (clk),
    .rst                (rst),
    .s_axis_tdata       (b_s_tdata),
    .s_axis_tkeep       (1'b0),
    .s_axis_tvalid      (b_s_tvalid),
    .s_axis_tready      (b_s_tready),
    .s_axis_tlast       (1'b0),
    .s_axis_tid         (8'h00),
    .s_axis_tdest       (8'h00),
    .s_axis_tuser       (1'b0),
    .m_axis_tdata       (b_m_tdata),
    .m_axis_tkeep       (b_m_tkeep),
    .m_axis_tvalid      (b_m_tvalid),
    .m_axis_tready      (b_m_tready),
    .m_axis_tlast       (b_m_tlast),
    .m_axis_tid         (b_m_tid),
    .m_axis_tdest       (b_m_tdest),
    .m_axis_tuser       (b_m_tuser),
    .flush              (1'b0),
    .status_count       (b_count),
    .status_full        (b_full),
    .status_empty       (b_empty),
    .status_almost_full (b_afull)
  );

  // ---------------------------------------------------------------- helpers -
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] pat [4];
  logic       mpush, mpop;
  int         sent, recv, cyc;

  initial begin
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    rst = 1'b1; a_flush = 1'b0;
    a_s_tdata = '0; a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_s_tuser = '0;
    a_m_tready = 1'b0;
    b_s_tdata = '0; b_s_tvalid = 1'b0; b_m_tready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state.
    check("rst_ready", a_s_tready, 1);
    check("rst_valid", a_m_tvalid, 0);
    check("rst_count", a_count, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full",  a_full, 0);
    check("rst_afull", a_afull, 0);

    // Fill with the consumer stalled.
    for (int k = 0; k < 4; k++) begin
      a_s_tdata = pat[k]; a_s_tvalid = 1'b1;
      a_s_tlast = (k == 3); a_s_tuser = 1'(k & 1);
      step();
      check("fill_count", a_count, k + 1);
      check("fill_afull", a_afull, (k + 1 >= 3));
      check("fill_ready", a_s_tready, (k + 1 < 4));
      check("fill_valid", a_m_tvalid, 1);
    end
    check("fill_full", a_full, 1);

    // Drain. On the first pop a new word is offered but must be refused.
    a_s_tdata = 8'h99; a_s_tvalid = 1'b1; a_s_tlast = 1'b0;
    a_m_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", a_m_tvalid, 1);
      check("drain_data",  a_m_tdata, pat[k]);
      check("drain_last",  a_m_tlast, (k == 3));
      check("drain_user",  a_m_tuser, k & 1);
      check("drain_keep",  a_m_tkeep, 1);
      step();
      a_s_tvalid = 1'b0;
      check("drain_count", a_count, 3 - k);
      check("drain_ready", a_s_tready, 1);
    end
    check("drain_empty", a_empty, 1);
    check("drain_vld0",  a_m_tvalid, 0);

    // Continuous stream: occupancy stays at 1, one word per cycle.
    a_s_tvalid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a_s_tdata = 8'(i);
      step();
      check("stream_count", a_count, 1);
      check("stream_data",  a_m_tdata, i);
    end
    a_s_tvalid = 1'b0;
    step();
    check("stream_end", a_count, 0);

    // Flush beats a same-cycle push.
    a_m_tready = 1'b0;
    a_s_tvalid = 1'b1;
    a_s_tdata = 8'h01; step();
    a_s_tdata = 8'h02; step();
    check("pre_flush_count", a_count, 2);
    a_flush = 1'b1; a_s_tdata = 8'hAA;
    step();
    a_flush = 1'b0; a_s_tvalid = 1'b0;
    check("flush_count", a_count, 0);
    check("flush_valid", a_m_tvalid, 0);
    check("flush_empty", a_empty, 1);
    a_s_tvalid = 1'b1; a_s_tdata = 8'h5B;
    step();
    a_s_tvalid = 1'b0;
    check("post_flush_count", a_count, 1);
    check("post_flush_data",  a_m_tdata, 8'h5B);
    a_m_tready = 1'b1;
    step();
    check("post_flush_pop", a_count, 0);

    // Reset in mid-stream beats a same-cycle push and pop.
    a_m_tready = 1'b0; a_s_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_s_tdata = 8'(8'h61 + k); step();
    end
    check("pre_rst_count", a_count, 3);
    rst = 1'b1; a_s_tdata = 8'h77; a_m_tready = 1'b1;
    step();
    rst = 1'b0; a_s_tvalid = 1'b0; a_m_tready = 1'b0;
    check("mid_rst_count", a_count, 0);
    check("mid_rst_ready", a_s_tready, 1);
    check("mid_rst_valid", a_m_tvalid, 0);
    a_s_tvalid = 1'b1; a_s_tdata = 8'h5A;
    step();
    a_s_tvalid = 1'b0;
    check("post_rst_valid", a_m_tvalid, 1);
    check("post_rst_data",  a_m_tdata, 8'h5A);
    a_m_tready = 1'b1;
    step();
    check("post_rst_pop", a_count, 0);

    // DEPTH=2 random handshake against the queue model.
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      b_s_tvalid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      b_s_tdata  = sent[7:0];
      b_m_tready = ($urandom_range(0, 1) == 1);
      check("b_ready", b_s_tready, (q.size() != 2));
      check("b_valid", b_m_tvalid, (q.size() != 0));
      mpush = b_s_tvalid && (q.size() != 2);
      mpop  = b_m_tready && (q.size() != 0);
      if (mpop) begin
        check("b_data", b_m_tdata, q[0]);
        check("b_last", b_m_tlast, 1);
        check("b_keep", b_m_tkeep, 1);
      end
      step();
      if (mpop) begin
        void'(q.pop_front());
        recv++;
      end
      if (mpush) begin
        q.push_back(sent[7:0]);
        sent++;
      end
      check("b_count", b_count, q.size());
      cyc++;
    end
    if (recv < 1000) begin
      total++;
      bad++;
      $error("FAIL b_timeout: received=%0d required=1000", recv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
